// File: rtl/mem_arbiter_ctrl.sv
// Byte-serial RAM port sequencer shared by instruction fetch and MEM.
// MEM has priority; every access ends with a one-cycle ready pulse.
module mem_arbiter_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din,
  output logic              stall_req_if,
  output logic              stall_req_mem
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t            state_q;
  logic              gnt_mem_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;
  logic [2:0]        cnt_q;
  logic [2:0]        nbytes_q;

  logic [ADDR_W-1:0] ram_a_q;
  logic [7:0]        ram_dout_q;
  logic              ram_wr_q;
  logic              if_ready_q;
  logic              mem_ready_q;
  logic [31:0]       if_data_q;
  logic [31:0]       mem_rdata_q;

  logic [1:0]        lane_d;
  logic [31:0]       merged_d;
  logic [ADDR_W-1:0] next_a_d;
  logic [7:0]        next_b_d;
  logic [2:0]        mem_n_d;

  function automatic logic [2:0] bytes_of(input logic [1:0] sz);
    logic [2:0] n;
    n = 3'd4;
    unique case (sz)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Byte lane bookkeeping: read capture trails address issue by two edges.
  always_comb begin
    lane_d   = cnt_q[1:0] - 2'd2;
    merged_d = buf_q | (32'(ram_din) << {lane_d, 3'b000});
    next_a_d = addr_q + ADDR_W'(cnt_q);
    next_b_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    mem_n_d  = bytes_of(mem_size);
  end

  // Arbitration and per-byte sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_mem_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      cnt_q       <= '0;
      nbytes_q    <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_req) begin
            gnt_mem_q <= 1'b1;
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
            nbytes_q  <= mem_n_d;
            buf_q     <= '0;
            cnt_q     <= 3'd1;
            ram_a_q   <= mem_addr;
            if (mem_we) begin
              state_q    <= WRITE;
              ram_dout_q <= mem_wdata[7:0];
              ram_wr_q   <= 1'b1;
            end else begin
              state_q <= READ;
            end
          end else if (if_req) begin
            gnt_mem_q <= 1'b0;
            addr_q    <= if_addr;
            nbytes_q  <= 3'd4;
            buf_q     <= '0;
            cnt_q     <= 3'd1;
            ram_a_q   <= if_addr;
            state_q   <= READ;
          end
        end
        READ: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q < nbytes_q) begin
            ram_a_q <= next_a_d;
          end
          if (cnt_q >= 3'd2) begin
            buf_q <= merged_d;
          end
          if (cnt_q == nbytes_q + 3'd1) begin
            state_q <= DONE;
            if (gnt_mem_q) begin
              mem_rdata_q <= merged_d;
              mem_ready_q <= 1'b1;
            end else begin
              if_data_q  <= merged_d;
              if_ready_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (cnt_q == nbytes_q) begin
            ram_wr_q    <= 1'b0;
            mem_ready_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            ram_a_q    <= next_a_d;
            ram_dout_q <= next_b_d;
            ram_wr_q   <= 1'b1;
            cnt_q      <= cnt_q + 3'd1;
          end
        end
        DONE: begin
          if_ready_q  <= 1'b0;
          mem_ready_q <= 1'b0;
          ram_a_q     <= '0;
          cnt_q       <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;
  assign if_ready  = if_ready_q;
  assign mem_ready = mem_ready_q;
  assign if_data   = if_data_q;
  assign mem_rdata = mem_rdata_q;

  assign stall_req_if  = if_req & ~if_ready_q;
  assign stall_req_mem = mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Scoreboard bench for mem_arbiter_ctrl with a byte RAM model
// and a flat-array reference memory.
module tb_mem_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic        stall_req_if;
  logic        stall_req_mem;

  mem_arbiter_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_ready(if_ready), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_dout(ram_dout),
    .ram_wr(ram_wr), .ram_din(ram_din),
    .stall_req_if(stall_req_if),
    .stall_req_mem(stall_req_mem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM device: 64 KiB aliased window, one-cycle read latency.
  logic [7:0]  phys [0:65535];
  logic        pk_en;
  logic [15:0] pk_a;
  logic [7:0]  pk_d;
  always @(posedge clk) begin
    if (pk_en) phys[pk_a] <= pk_d;
    else if (ram_wr) phys[ram_a[15:0]] <= ram_dout;
    ram_din <= phys[ram_a[15:0]];
  end

  logic [7:0]  ref_mem [0:65535];
  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] last_ld = 32'h0;
  logic [31:0] a_tr [0:8191];
  logic        w_tr [0:8191];
  logic [7:0]  d_tr [0:8191];
  int checks = 0;
  int failures = 0;

  task automatic ceq(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  function automatic logic [7:0] rr(input logic [31:0] a);
    return ref_mem[a[15:0]];
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    pk_en = 1'b1;
    pk_a = a[15:0];
    pk_d = d;
    ref_mem[a[15:0]] = d;
    @(posedge clk); #1;
    pk_en = 1'b0;
  endtask

  // Monitor: trace RAM port and score every ready pulse.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      a_tr[cyc & 8191] = ram_a;
      w_tr[cyc & 8191] = ram_wr;
      d_tr[cyc & 8191] = ram_dout;
      if (!rst) begin
        ceq("stall_if", 32'(stall_req_if), 32'(if_req & ~if_ready));
        ceq("stall_mem", 32'(stall_req_mem), 32'(mem_req & ~mem_ready));
        if (if_ready) begin
          if (if_q.size() == 0) bad("if_spurious");
          else begin
            e = if_q.pop_front();
            ceq("if_data", if_data, e);
          end
        end
        if (mem_ready) begin
          if (mem_q.size() == 0) bad("mem_spurious");
          else begin
            e = mem_q.pop_front();
            ceq("mem_rdata", mem_rdata, e);
          end
        end
      end
    end
  end

  // gofs < 0 skips timing checks; otherwise grant expected gofs edges late.
  task automatic issue_if(input logic [31:0] a, input int gofs);
    int g;
    bit got;
    bit st_ok;
    logic [31:0] ak;
    @(posedge clk); #1;
    if_q.push_back({rr(a + 3), rr(a + 2), rr(a + 1), rr(a)});
    if_addr = a;
    if_req = 1'b1;
    g = cyc + 1 + gofs;
    got = 1'b0;
    st_ok = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (if_ready) got = 1'b1;
      else if (!stall_req_if) st_ok = 1'b0;
    end
    if (!got) bad("if_timeout");
    else if (gofs >= 0) begin
      ceq("if_latency", cyc - g, 5);
      ceq("if_stall_wait", 32'(st_ok), 1);
      ceq("if_stall_pulse", 32'(stall_req_if), 0);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    if (got && gofs >= 0) begin
      for (int k = 0; k < 4; k++) begin
        ak = a + 32'(k);
        ceq("if_ram_a", a_tr[(g + k) & 8191], ak);
        ceq("if_ram_wr", 32'(w_tr[(g + k) & 8191]), 0);
      end
    end
  endtask

  task automatic issue_mem(input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int gofs);
    int n;
    int g;
    bit got;
    logic [31:0] e;
    logic [31:0] ak;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    @(posedge clk); #1;
    e = 32'h0;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      if (we) ref_mem[ak[15:0]] = wd[8*k +: 8];
      else e = e | (32'(rr(ak)) << (8 * k));
    end
    if (!we) last_ld = e;
    mem_q.push_back(last_ld);
    mem_we = we;
    mem_size = sz;
    mem_addr = a;
    mem_wdata = wd;
    mem_req = 1'b1;
    g = cyc + 1 + gofs;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (mem_ready) got = 1'b1;
    end
    if (!got) bad("mem_timeout");
    else if (gofs >= 0) ceq("mem_latency", cyc - g, we ? n : n + 1);
    @(posedge clk); #1;
    mem_req = 1'b0;
    if (got && gofs >= 0) begin
      for (int k = 0; k < n; k++) begin
        ak = a + 32'(k);
        ceq("mem_ram_a", a_tr[(g + k) & 8191], ak);
        ceq("mem_ram_wr", 32'(w_tr[(g + k) & 8191]), 32'(we));
        if (we) ceq("mem_ram_dout", 32'(d_tr[(g + k) & 8191]),
                    32'(wd[8*k +: 8]));
      end
      if (we) ceq("mem_wr_end", 32'(w_tr[(g + n) & 8191]), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if_req = 1'b0;
    if_addr = '0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_size = '0;
    mem_addr = '0;
    mem_wdata = '0;
    pk_en = 1'b0;
    pk_a = '0;
    pk_d = '0;

    poke(32'h100, 8'h13);
    poke(32'h101, 8'h00);
    poke(32'h102, 8'h00);
    poke(32'h103, 8'h00);
    poke(32'h30, 8'hF0);
    poke(32'hFFFF_FFFE, 8'h11);
    poke(32'hFFFF_FFFF, 8'h22);
    poke(32'h0, 8'h33);
    poke(32'h1, 8'h44);
    for (int i = 0; i < 256; i++)
      poke(32'h1000 + 32'(i), 8'($urandom));
    for (int i = 0; i < 68; i++)
      poke(32'h8000 + 32'(i), 8'($urandom));

    ceq("rst_if_ready", 32'(if_ready), 0);
    ceq("rst_mem_ready", 32'(mem_ready), 0);
    ceq("rst_ram_wr", 32'(ram_wr), 0);
    ceq("rst_ram_a", ram_a, 0);
    ceq("rst_ram_dout", 32'(ram_dout), 0);
    ceq("rst_if_data", if_data, 0);
    ceq("rst_mem_rdata", mem_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    issue_if(32'h100, 0);
    issue_mem(1'b1, 2'd1, 32'h2002, 32'hAABB_CCDD, 0);
    issue_mem(1'b0, 2'd1, 32'h2002, 32'h0, 0);
    issue_mem(1'b0, 2'd0, 32'h30, 32'h0, 0);

    fork
      issue_mem(1'b0, 2'd2, 32'h8000, 32'h0, 0);
      issue_if(32'h1000, 7);
    join

    issue_mem(1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0, 0);

    @(posedge clk); #1;
    mem_we = 1'b1;
    mem_size = 2'd2;
    mem_addr = 32'h7000;
    mem_wdata = 32'h0102_0304;
    mem_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    ceq("rst_mid_pre_wr", 32'(ram_wr), 1);
    ceq("rst_mid_pre_a", ram_a, 32'h7001);
    rst = 1'b1;
    @(posedge clk); #1;
    mem_req = 1'b0;
    ceq("rst_mid_wr", 32'(ram_wr), 0);
    ceq("rst_mid_ready", 32'(mem_ready), 0);
    ceq("rst_mid_a", ram_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_ld = 32'h0;
    repeat (4) begin
      @(negedge clk);
      ceq("rst_no_ready", 32'(mem_ready), 0);
    end
    issue_mem(1'b0, 2'd2, 32'h8004, 32'h0, 0);

    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          issue_if(32'h1000 + 32'($urandom_range(0, 252)), -1);
        end
      end
      begin
        logic [1:0] sz;
        logic we;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          sz = 2'($urandom_range(0, 3));
          we = 1'($urandom_range(0, 1));
          issue_mem(we, sz, 32'h8000 + 32'($urandom_range(0, 60)),
                    32'($urandom), -1);
        end
      end
    join

    repeat (4) @(posedge clk);
    if (if_q.size() != 0) bad("if_queue_left");
    if (mem_q.size() != 0) bad("mem_queue_left");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
